// File: rtl/set_sequencer_pkg.sv
// Shared types for the set sequencer: FSM state encoding and the default-sized command record.
package set_sequencer_pkg;

  localparam int DEF_SET_SIZE   = 5;
  localparam int DEF_SET_WIDTH  = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_DLY_WIDTH  = 16;
  localparam int DEF_IDX_W      = $clog2(DEF_SET_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    APPLY = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [DEF_IDX_W-1:0]     idx;
    logic [DEF_SET_WIDTH-1:0] value;
    logic [DEF_DLY_WIDTH-1:0] delay;
  } seq_cmd_t;

endpackage

// File: rtl/set_seq_fifo.sv
// Synchronous command FIFO; a flush or reset empties it and drops any push in that cycle.
module set_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/set_sequencer.sv
// Queued, delayed writes into a bank of registered set values.
// Optional SET_SEQUENCER_TIMESTAMP_EN adds a cycle counter and o_applied_time.
//
// state | meaning
// IDLE  | waiting for a queued command; pops the FIFO head when one is present
// WAIT  | counting the popped command's delay down to terminal count 1
// APPLY | writing the value into its slot (or flagging a bad index)
module set_sequencer
  import set_sequencer_pkg::*;
#(
  parameter int SET_SIZE   = DEF_SET_SIZE,
  parameter int SET_WIDTH  = DEF_SET_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DLY_WIDTH  = DEF_DLY_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SET_SIZE*SET_WIDTH-1:0]   i_init_values,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic [$clog2(SET_SIZE)-1:0]     i_cmd_idx,
  input  logic [SET_WIDTH-1:0]            i_cmd_value,
  input  logic [DLY_WIDTH-1:0]            i_cmd_delay,
  input  logic                            i_flush,
  output logic [SET_SIZE*SET_WIDTH-1:0]   o_set_signals,
  output logic                            o_applied,
  output logic [$clog2(SET_SIZE)-1:0]     o_applied_idx,
  output logic                            o_busy,
`ifdef SET_SEQUENCER_TIMESTAMP_EN
  output logic [DLY_WIDTH+15:0]           o_applied_time,
`endif
  output logic                            o_err_idx
);

  localparam int IDX_W   = $clog2(SET_SIZE);
  localparam int ENTRY_W = IDX_W + SET_WIDTH + DLY_WIDTH;

  seq_state_t             state;
  seq_state_t             next_state;
  logic [DLY_WIDTH-1:0]   cnt;
  logic [IDX_W-1:0]       cur_idx;
  logic [SET_WIDTH-1:0]   cur_value;

  logic [ENTRY_W-1:0]     fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [IDX_W-1:0]       head_idx;
  logic [SET_WIDTH-1:0]   head_value;
  logic [DLY_WIDTH-1:0]   head_delay;

  logic                   push;
  logic                   pop;
  logic                   apply_ok;
  logic                   apply_err;
  logic                   in_range;

  assign o_cmd_ready = !fifo_full;
  assign push        = i_cmd_valid && o_cmd_ready && !i_flush;
  assign {head_idx, head_value, head_delay} = fifo_rdata;
  assign in_range    = int'(cur_idx) < SET_SIZE;
  assign o_busy      = !rst && ((fifo_count != '0) || (state != IDLE));

  set_seq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (i_flush),
    .wdata ({i_cmd_idx, i_cmd_value, i_cmd_delay}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    apply_ok   = 1'b0;
    apply_err  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = (head_delay != '0) ? WAIT : APPLY;
        end
      end
      WAIT: begin
        if (cnt == DLY_WIDTH'(1)) next_state = APPLY;
      end
      APPLY: begin
        apply_ok   = in_range;
        apply_err  = !in_range;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Flush wins over everything: nothing is popped or written this cycle.
    if (i_flush) begin
      next_state = IDLE;
      pop        = 1'b0;
      apply_ok   = 1'b0;
      apply_err  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      cur_idx       <= '0;
      cur_value     <= '0;
      o_set_signals <= i_init_values;
      o_applied     <= 1'b0;
      o_applied_idx <= '0;
      o_err_idx     <= 1'b0;
    end else begin
      state     <= next_state;
      o_applied <= apply_ok;
      if (pop) begin
        cnt       <= head_delay;
        cur_idx   <= head_idx;
        cur_value <= head_value;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - DLY_WIDTH'(1);
      end
      if (apply_ok) begin
        for (int k = 0; k < SET_SIZE; k++) begin
          if (k == int'(cur_idx)) o_set_signals[k*SET_WIDTH +: SET_WIDTH] <= cur_value;
        end
        o_applied_idx <= cur_idx;
      end
      if (apply_err) o_err_idx <= 1'b1;
    end
  end

`ifdef SET_SEQUENCER_TIMESTAMP_EN
  logic [DLY_WIDTH+15:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt         <= '0;
      o_applied_time <= '0;
    end else begin
      ts_cnt <= ts_cnt + (DLY_WIDTH+16)'(1);
      if (apply_ok) o_applied_time <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_set_sequencer.sv
// Bench for set_sequencer: vector table of commands plus hand sequences for fill, flush, reset and bad index.
module tb_set_sequencer;
  import set_sequencer_pkg::*;

  localparam int SS = 5;
  localparam int SW = 32;
  localparam int DW = 16;
  localparam int IW = 3;
  localparam int VW = SS * SW;

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] i_init_values;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [IW-1:0] i_cmd_idx;
  logic [SW-1:0] i_cmd_value;
  logic [DW-1:0] i_cmd_delay;
  logic          i_flush;
  logic [VW-1:0] o_set_signals;
  logic          o_applied;
  logic [IW-1:0] o_applied_idx;
  logic          o_busy;
  logic          o_err_idx;
`ifdef SET_SEQUENCER_TIMESTAMP_EN
  logic [DW+15:0] o_applied_time;
  logic [DW+15:0] last_time = '0;
  logic [DW+15:0] prev_time = '0;
`endif

  set_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .i_init_values (i_init_values),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_idx     (i_cmd_idx),
    .i_cmd_value   (i_cmd_value),
    .i_cmd_delay   (i_cmd_delay),
    .i_flush       (i_flush),
    .o_set_signals (o_set_signals),
    .o_applied     (o_applied),
    .o_applied_idx (o_applied_idx),
    .o_busy        (o_busy),
`ifdef SET_SEQUENCER_TIMESTAMP_EN
    .o_applied_time(o_applied_time),
`endif
    .o_err_idx     (o_err_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] value;
  } exp_t;

  typedef struct {
    seq_cmd_t cmd;
    int       exp_lat;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] shadow [SS];
  vec_t        vecs [6];
  int total = 0, bad = 0, cyc = 0;
  int apply_count = 0, last_apply_cyc = 0, prev_apply_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack_shadow();
    logic [VW-1:0] v;
    for (int k = 0; k < SS; k++) v[k*SW +: SW] = shadow[k];
    return v;
  endfunction

  function automatic void load_shadow(input logic [VW-1:0] v);
    for (int k = 0; k < SS; k++) shadow[k] = v[k*SW +: SW];
  endfunction

  // Scoreboard consumer: every o_applied pulse must match the oldest accepted in-range command.
  always @(negedge clk) begin
    if (!rst && o_applied) begin
      if (sb.size() == 0) begin
        check("apply_expected", VW'(o_applied), VW'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("applied_idx", VW'(o_applied_idx), VW'(e.idx));
        check("applied_value", VW'(o_set_signals[e.idx*SW +: SW]), VW'(e.value));
        shadow[e.idx] = e.value;
      end
      apply_count++;
      prev_apply_cyc = last_apply_cyc;
      last_apply_cyc = cyc;
`ifdef SET_SEQUENCER_TIMESTAMP_EN
      prev_time = last_time;
      last_time = o_applied_time;
`endif
    end
  end

  task automatic push_cmd(input seq_cmd_t c, input int limit, output int acc_cyc);
    int w;
    w = 0;
    i_cmd_idx   = c.idx;
    i_cmd_value = c.value;
    i_cmd_delay = c.delay;
    i_cmd_valid = 1'b1;
    while (!o_cmd_ready && w < limit) begin
      @(negedge clk);
      w++;
    end
    if (!o_cmd_ready) begin
      check("push_timeout", VW'(o_cmd_ready), VW'(1));
      i_cmd_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    i_cmd_valid = 1'b0;
    if (int'(c.idx) < SS) sb.push_back('{int'(c.idx), c.value});
  endtask

  task automatic wait_apply(input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_applied) begin
        at_cyc = cyc;
        return;
      end
    end
    check("apply_timeout", VW'(0), VW'(1));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [VW-1:0] init_a, init_b;
    int acc, at, first_acc, cnt0;
    seq_cmd_t c;

    for (int k = 0; k < SS; k++) begin
      init_a[k*SW +: SW] = 32'h1000 + k;
      init_b[k*SW +: SW] = 32'h5500_0000 + k;
    end
    init_a[2*SW +: SW] = 32'hA5;

    vecs[0] = '{'{3'd1, 32'h1234,     16'd10}, 12};
    vecs[1] = '{'{3'd0, 32'hDEADBEEF, 16'd0},  2};
    vecs[2] = '{'{3'd4, 32'hCAFEF00D, 16'd1},  3};
    vecs[3] = '{'{3'd2, 32'h5A5A,     16'd3},  5};
    vecs[4] = '{'{3'd3, 32'hFFFFFFFF, 16'd0},  2};
    vecs[5] = '{'{3'd1, 32'h0,        16'd2},  4};

    rst = 1'b1; i_init_values = init_a; i_cmd_valid = 1'b0; i_flush = 1'b0;
    i_cmd_idx = '0; i_cmd_value = '0; i_cmd_delay = '0;
    load_shadow(init_a);

    // Reset held three cycles.
    repeat (3) @(negedge clk);
    check("rst_busy", VW'(o_busy), VW'(0));
    check("rst_applied", VW'(o_applied), VW'(0));
    check("rst_err", VW'(o_err_idx), VW'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_signals", o_set_signals, init_a);
    check("rst_slot2", VW'(o_set_signals[2*SW +: SW]), VW'(32'hA5));
    check("rst_ready", VW'(o_cmd_ready), VW'(1));
    check("rst_applied_idx", VW'(o_applied_idx), VW'(0));

    // Table of single commands: latency from accept edge is delay+2.
    for (int i = 0; i < 6; i++) begin
      push_cmd(vecs[i].cmd, 4, acc);
      wait_apply(vecs[i].exp_lat + 10, at);
      check($sformatf("vec%0d_latency", i), VW'(at - acc), VW'(vecs[i].exp_lat));
      @(negedge clk);
      check($sformatf("vec%0d_pulse_end", i), VW'(o_applied), VW'(0));
      check($sformatf("vec%0d_signals", i), o_set_signals, pack_shadow());
    end

    // Two back-to-back delay-0 commands land two cycles apart.
    cnt0 = apply_count;
    push_cmd('{3'd0, 32'h11, 16'd0}, 4, acc);
    push_cmd('{3'd2, 32'h22, 16'd0}, 4, acc);
    for (int i = 0; i < 20 && apply_count < cnt0 + 2; i++) @(negedge clk);
    @(negedge clk);
    check("b2b_count", VW'(apply_count - cnt0), VW'(2));
    check("b2b_spacing", VW'(last_apply_cyc - prev_apply_cyc), VW'(2));
`ifdef SET_SEQUENCER_TIMESTAMP_EN
    check("ts_spacing", VW'(last_time - prev_time), VW'(2));
`endif
    check("b2b_signals", o_set_signals, pack_shadow());

    // Out-of-range index: sticky error, no write, no pulse.
    cnt0 = apply_count;
    push_cmd('{3'd7, 32'h99, 16'd0}, 4, acc);
    idle_cycles(6);
    check("err_flag", VW'(o_err_idx), VW'(1));
    check("err_no_apply", VW'(apply_count), VW'(cnt0));
    check("err_signals", o_set_signals, pack_shadow());
    check("err_idle", VW'(o_busy), VW'(0));
    push_cmd('{3'd0, 32'h42, 16'd0}, 4, acc);
    wait_apply(10, at);
    @(negedge clk);
    check("err_sticky", VW'(o_err_idx), VW'(1));

    // Fill: first command is popped at once, so 9 fit; the 10th waits for the next pop.
    for (int i = 0; i < 9; i++) begin
      c = '{IW'(i % SS), 32'hF000 + i, 16'd100};
      push_cmd(c, 4, acc);
      if (i == 0) first_acc = acc;
    end
    check("fill_ready_low", VW'(o_cmd_ready), VW'(0));
    check("fill_busy", VW'(o_busy), VW'(1));
    cnt0 = apply_count;
    push_cmd('{3'd4, 32'hF00D, 16'd100}, 300, acc);
    check("fill_10th_after_pop", VW'(acc > last_apply_cyc), VW'(1));
    check("fill_10th_cycle", VW'(acc - first_acc), VW'(104));
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    sb.delete();
    check("fill_flush_busy", VW'(o_busy), VW'(0));

    // Flush mid-WAIT with 3 queued, plus a push coincident with the flush.
    for (int i = 0; i < 4; i++) push_cmd('{IW'(i), 32'hAB00 + i, 16'd50}, 4, acc);
    idle_cycles(10);
    check("flush_pre_busy", VW'(o_busy), VW'(1));
    cnt0 = apply_count;
    i_cmd_idx = 3'd0; i_cmd_value = 32'h777; i_cmd_delay = 16'd0;
    i_cmd_valid = 1'b1; i_flush = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0; i_flush = 1'b0;
    sb.delete();
    check("flush_busy", VW'(o_busy), VW'(0));
    check("flush_ready", VW'(o_cmd_ready), VW'(1));
    check("flush_hold", o_set_signals, pack_shadow());
    idle_cycles(70);
    check("flush_no_apply", VW'(apply_count), VW'(cnt0));
    check("flush_hold_late", o_set_signals, pack_shadow());

    // Reset during WAIT discards the command and reloads init values.
    cnt0 = apply_count;
    push_cmd('{3'd3, 32'hBEEF, 16'd20}, 4, acc);
    idle_cycles(5);
    rst = 1'b1; i_init_values = init_b;
    idle_cycles(2);
    rst = 1'b0;
    sb.delete();
    load_shadow(init_b);
    @(negedge clk);
    check("rst_wait_signals", o_set_signals, init_b);
    check("rst_wait_err", VW'(o_err_idx), VW'(0));
    idle_cycles(40);
    check("rst_wait_no_apply", VW'(apply_count), VW'(cnt0));
    check("rst_wait_hold", o_set_signals, init_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
